// File: rtl/mac_cluster_seq_if.sv
// Job command, operand stream and result port bundle for mac_cluster_seq.
// The slave modport is the sequencer side; master is the job source/result sink.
interface mac_cluster_seq_if #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 32,
  parameter int LEN_WIDTH      = 16
);
  logic                                    cmd_valid;
  logic                                    cmd_ready;
  logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] cmd_cfg;
  logic [LEN_WIDTH-1:0]                    cmd_len;
  logic                                    op_valid;
  logic                                    op_ready;
  logic [8*MAC_MIN_WIDTH-1:0]              op_data;
  logic                                    res_valid;
  logic                                    res_ready;
  logic [4*MAC_ACC_WIDTH-1:0]              res_data;

  modport master (
    output cmd_valid, cmd_cfg, cmd_len, op_valid, op_data, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_cfg, cmd_len, op_valid, op_data, res_ready,
    output cmd_ready, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_cluster_seq.sv
// Job sequencer for one mac_cluster: loads cfg, streams operand beats with
// stall gating, drains the cluster pipeline and returns the four accumulators.
module mac_cluster_seq #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 32,
  parameter int PIPE_LAT       = 4,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  mac_cluster_seq_if.slave                        bus,
  output logic                                    mac_en,
  output logic                                    mac_cset,
  output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
  output logic [8*MAC_MIN_WIDTH-1:0]              mac_ops,
  input  logic [4*MAC_ACC_WIDTH-1:0]              mac_out,
  output logic                                    busy
);

  localparam int CFG_W   = 4*MAC_ACC_WIDTH+MAC_CONF_WIDTH;
  localparam int OPS_W   = 8*MAC_MIN_WIDTH;
  localparam int RES_W   = 4*MAC_ACC_WIDTH;
  localparam int DRAIN_W = $clog2(PIPE_LAT+1);

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    STREAM,
    DRAIN,
    RESULT
  } state_t;

  state_t               state_q, state_d;
  logic [CFG_W-1:0]     cfg_q, cfg_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [RES_W-1:0]     res_q, res_d;

  logic cmd_ready;
  logic op_ready;
  logic res_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      res_q       <= res_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    res_d       = res_q;
    cmd_ready   = 1'b0;
    op_ready    = 1'b0;
    res_valid   = 1'b0;
    mac_en      = 1'b0;
    mac_cset    = 1'b0;
    mac_ops     = '0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cfg_d      = bus.cmd_cfg;
          beat_cnt_d = bus.cmd_len;
          state_d    = CFG;
        end
      end

      CFG: begin
        mac_cset = 1'b1;
        if (beat_cnt_q != '0) begin
          state_d = STREAM;
        end else begin
          // An empty job still drains so the result path is uniform.
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_W'(PIPE_LAT);
        end
      end

      STREAM: begin
        op_ready = 1'b1;
        mac_ops  = bus.op_data;
        mac_en   = bus.op_valid;
        if (bus.op_valid) begin
          beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
          if (beat_cnt_q == LEN_WIDTH'(1)) begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_W'(PIPE_LAT);
          end
        end
      end

      DRAIN: begin
        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        if (drain_cnt_q > DRAIN_W'(1)) begin
          mac_en = 1'b1;
        end else begin
          // Stop before zero operands can reach the outputs, then capture.
          res_d   = mac_out;
          state_d = RESULT;
        end
      end

      RESULT: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.op_ready  = op_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_q;
  assign mac_cfg       = cfg_q;
  assign busy          = (state_q != IDLE);

endmodule
